// File: rtl/myproject_sdiv_31s_15ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module   : myproject_sdiv_31s_15ns_16_seq
// Purpose  : Sequential restoring divider that undoes a 15-bit-unsigned x
//            16-bit-signed multiply. A signed accumulator value is divided by
//            an unsigned scale. The result is a saturated signed 16-bit
//            quotient, truncated toward zero, plus a remainder whose sign
//            follows the dividend. One quotient bit is produced per clock.
//
// Ports    : ap_clk     in   clock, rising edge
//            ap_rst     in   asynchronous active-high reset
//            in_valid   in   operands valid
//            in_ready   out  block can accept operands
//            dividend   in   [din0_WIDTH] signed dividend
//            divisor    in   [din1_WIDTH] unsigned divisor
//            out_valid  out  result valid (held until out_ready)
//            out_ready  in   consumer accepts result
//            quot       out  [dout_WIDTH] signed quotient, saturated
//            rem        out  [dout_WIDTH] signed remainder
//            ovf        out  quotient was clamped (nonzero divisor)
//            dbz        out  divisor was zero
//
// Revision : 1.0 - initial release
// ============================================================================
module myproject_sdiv_31s_15ns_16_seq #(
    parameter int din0_WIDTH = 31,
    parameter int din1_WIDTH = 15,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] dividend,
    input  logic [din1_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [dout_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(din0_WIDTH);
    localparam int c_PART_W = din1_WIDTH + 1;

    // Bit counter start: one CALC edge per dividend bit, ending at zero.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(din0_WIDTH - 1);

    // Largest quotient magnitudes representable in dout_WIDTH signed bits.
    localparam logic [din0_WIDTH-1:0] c_POS_LIMIT =
        {{(din0_WIDTH - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] c_NEG_LIMIT =
        {{(din0_WIDTH - dout_WIDTH){1'b0}}, 1'b1, {(dout_WIDTH - 1){1'b0}}};

    // Saturated output codes.
    localparam logic [dout_WIDTH-1:0] c_Q_MAX = {1'b0, {(dout_WIDTH - 1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] c_Q_MIN = {1'b1, {(dout_WIDTH - 1){1'b0}}};

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_in_ready;
    logic                    r_neg;        // dividend was negative
    logic                    r_dbz_pend;   // divisor was zero for this op
    logic [din0_WIDTH-1:0]   r_mag;        // |dividend|, shifted out MSB first
    logic [din1_WIDTH-1:0]   r_divisor;
    logic [c_PART_W-1:0]     r_part;       // partial remainder
    logic [din0_WIDTH-1:0]   r_qmag;       // unsigned quotient magnitude
    logic [c_CNT_W-1:0]      r_cnt;

    logic                    r_out_valid;
    logic [dout_WIDTH-1:0]   r_quot;
    logic [dout_WIDTH-1:0]   r_rem;
    logic                    r_ovf;
    logic                    r_dbz;

    // ------------------------------------------------------------------------
    // Operand conditioning
    // ------------------------------------------------------------------------
    logic                  w_dividend_neg;
    logic [din0_WIDTH-1:0] w_dividend_mag;
    logic                  w_accept;

    // The most negative dividend negates to a magnitude that still fits in
    // din0_WIDTH unsigned bits, so this magnitude is exact.
    assign w_dividend_neg = dividend[din0_WIDTH-1];
    assign w_dividend_mag = w_dividend_neg ? (~dividend + 1'b1) : dividend;
    assign w_accept       = r_in_ready & in_valid;

    // ------------------------------------------------------------------------
    // Restoring step
    // ------------------------------------------------------------------------
    logic [c_PART_W-1:0] w_shift;
    logic [c_PART_W-1:0] w_divisor_ext;
    logic [c_PART_W-1:0] w_sub;
    logic                w_ge;

    // The partial remainder stays below the divisor, so after the shift it
    // still fits in din1_WIDTH+1 bits and the top bit is discarded safely.
    assign w_shift       = {r_part[c_PART_W-2:0], r_mag[din0_WIDTH-1]};
    assign w_divisor_ext = {1'b0, r_divisor};
    assign w_ge          = (w_shift >= w_divisor_ext);
    assign w_sub         = w_shift - w_divisor_ext;

    // ------------------------------------------------------------------------
    // Sign application and saturation
    // ------------------------------------------------------------------------
    logic                  w_pos_ovf;
    logic                  w_neg_ovf;
    logic [dout_WIDTH-1:0] w_q_low;
    logic [dout_WIDTH-1:0] w_q_signed;
    logic [dout_WIDTH-1:0] w_rem_low;
    logic [dout_WIDTH-1:0] w_rem_signed;

    // Negative results may reach one count further than positive ones.
    assign w_pos_ovf    = (r_qmag > c_POS_LIMIT);
    assign w_neg_ovf    = (r_qmag > c_NEG_LIMIT);
    assign w_q_low      = r_qmag[dout_WIDTH-1:0];
    assign w_q_signed   = r_neg ? (~w_q_low + 1'b1) : w_q_low;
    // The remainder is strictly below the divisor, so it never needs clamping.
    assign w_rem_low    = dout_WIDTH'(r_part);
    assign w_rem_signed = r_neg ? (~w_rem_low + 1'b1) : w_rem_low;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_neg       <= 1'b0;
            r_dbz_pend  <= 1'b0;
            r_mag       <= '0;
            r_divisor   <= '0;
            r_part      <= '0;
            r_qmag      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_neg      <= w_dividend_neg;
                        r_mag      <= w_dividend_mag;
                        r_divisor  <= divisor;
                        r_dbz_pend <= (divisor == '0);
                        r_part     <= '0;
                        r_qmag     <= '0;
                        r_cnt      <= c_CNT_LOAD;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CALC;
                    end else begin
                        // Rises on the first edge after reset release.
                        r_in_ready <= 1'b1;
                    end
                end

                ST_CALC: begin
                    r_part <= w_ge ? w_sub : w_shift;
                    r_qmag <= {r_qmag[din0_WIDTH-2:0], w_ge};
                    r_mag  <= {r_mag[din0_WIDTH-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_FIX: begin
                    if (r_dbz_pend) begin
                        // Divide by zero reports the saturated value toward
                        // the dividend's sign; the datapath result is unused.
                        r_quot <= r_neg ? c_Q_MIN : c_Q_MAX;
                        r_rem  <= '0;
                        r_ovf  <= 1'b0;
                    end else if (!r_neg && w_pos_ovf) begin
                        r_quot <= c_Q_MAX;
                        r_rem  <= w_rem_signed;
                        r_ovf  <= 1'b1;
                    end else if (r_neg && w_neg_ovf) begin
                        r_quot <= c_Q_MIN;
                        r_rem  <= w_rem_signed;
                        r_ovf  <= 1'b1;
                    end else begin
                        r_quot <= w_q_signed;
                        r_rem  <= w_rem_signed;
                        r_ovf  <= 1'b0;
                    end
                    r_dbz       <= r_dbz_pend;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign quot      = r_quot;
    assign rem       = r_rem;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_myproject_sdiv_31s_15ns_16_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_myproject_sdiv_31s_15ns_16_seq
// Purpose  : Self-checking bench for the sequential signed/unsigned divider.
//            Expected results come from plain integer division with
//            saturation applied afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_sdiv_31s_15ns_16_seq;

    logic               ap_clk;
    logic               ap_rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [30:0] dividend;
    logic        [14:0] divisor;
    logic               out_valid;
    logic               out_ready;
    logic        [15:0] quot;
    logic        [15:0] rem;
    logic               ovf;
    logic               dbz;

    int checks;
    int failures;

    myproject_sdiv_31s_15ns_16_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .ovf       (ovf),
        .dbz       (dbz)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    // Reference: truncating integer division, then clamp to 16-bit signed.
    function automatic void ref_div(input longint a, input longint b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic ov, output logic dz);
        longint qq;
        longint rr;
        if (b == 0) begin
            dz = 1'b1;
            ov = 1'b0;
            q  = (a >= 0) ? 16'h7FFF : 16'h8000;
            r  = 16'h0000;
        end else begin
            dz = 1'b0;
            qq = a / b;
            rr = a % b;
            r  = rr[15:0];
            if (qq > 32767) begin
                q  = 16'h7FFF;
                ov = 1'b1;
            end else if (qq < -32768) begin
                q  = 16'h8000;
                ov = 1'b1;
            end else begin
                q  = qq[15:0];
                ov = 1'b0;
            end
        end
    endfunction

    // Drives one operation with out_ready high and reports what was observed.
    // Called and left at a falling edge.
    task automatic run_op(input logic signed [30:0] a, input logic [14:0] b,
                          output int lat, output logic [15:0] q, output logic [15:0] r,
                          output logic ov, output logic dz,
                          output logic ov_after, output logic ir_after);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        dividend = 31'($urandom);
        divisor  = 15'($urandom);
        lat = 0;
        while (lat < 200) begin
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
        q  = quot;
        r  = rem;
        ov = ovf;
        dz = dbz;
        @(posedge ap_clk);
        @(negedge ap_clk);
        ov_after = out_valid;
        ir_after = in_ready;
    endtask

    task automatic test_reset();
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge ap_clk);
        checks++;
        if ({in_ready, out_valid, ovf, dbz} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got in_ready/out_valid/ovf/dbz=%b want 0000",
                     {in_ready, out_valid, ovf, dbz});
        end
        checks++;
        if ({quot, rem} !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got quot=%h rem=%h want 0", quot, rem);
        end
        ap_rst = 1'b0;
        @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic signed [30:0] ta [10];
        logic        [14:0] tb [10];
        int lat;
        logic [15:0] q, r, eq, er;
        logic ov, dz, eov, edz, ova, ira;
        ta[0] = 31'sd100;        tb[0] = 15'd7;
        ta[1] = -31'sd100;       tb[1] = 15'd7;
        ta[2] = 31'sd0;          tb[2] = 15'd3;
        ta[3] = 31'sd32768;      tb[3] = 15'd1;
        ta[4] = -31'sd1073741824; tb[4] = 15'd1;
        ta[5] = -31'sd32768;     tb[5] = 15'd1;
        ta[6] = 31'sd1073741823; tb[6] = 15'd32767;
        ta[7] = 31'sd5;          tb[7] = 15'd0;
        ta[8] = -31'sd5;         tb[8] = 15'd0;
        ta[9] = -31'sd3;         tb[9] = 15'd7;
        for (int i = 0; i < 10; i++) begin
            run_op(ta[i], tb[i], lat, q, r, ov, dz, ova, ira);
            ref_div(longint'(ta[i]), longint'(tb[i]), eq, er, eov, edz);
            checks++;
            if (lat != 32) begin
                failures++;
                $display("FAIL dir%0d_latency got %0d want 32", i, lat);
            end
            checks++;
            if ({q, r, ov, dz} !== {eq, er, eov, edz}) begin
                failures++;
                $display("FAIL dir%0d_result a=%0d b=%0d got q=%0d r=%0d ovf=%b dbz=%b want q=%0d r=%0d ovf=%b dbz=%b",
                         i, ta[i], tb[i], $signed(q), $signed(r), ov, dz,
                         $signed(eq), $signed(er), eov, edz);
            end
            checks++;
            if ({ova, ira} !== 2'b01) begin
                failures++;
                $display("FAIL dir%0d_handshake got out_valid=%b in_ready=%b want 0 1",
                         i, ova, ira);
            end
        end
    endtask

    task automatic test_random();
        int lat, errs;
        logic signed [30:0] a;
        logic [14:0] b;
        logic [15:0] q, r, eq, er;
        logic ov, dz, eov, edz, ova, ira;
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 31'($urandom);
                1: a = 31'(int'($urandom_range(0, 140000)) - 70000);
                2: a = 31'(int'($urandom_range(0, 2000)) - 1000);
                default: a = ($urandom_range(0, 1) == 1) ? -31'sd1073741824 : 31'sd1073741823;
            endcase
            case ($urandom_range(0, 9))
                0: b = 15'd0;
                1, 2, 3: b = 15'($urandom_range(1, 16));
                4: b = 15'd32767;
                default: b = 15'($urandom_range(1, 32767));
            endcase
            run_op(a, b, lat, q, r, ov, dz, ova, ira);
            ref_div(longint'(a), longint'(b), eq, er, eov, edz);
            checks++;
            if (lat != 32 || {q, r, ov, dz} !== {eq, er, eov, edz} || {ova, ira} !== 2'b01) begin
                failures++;
                errs++;
                $display("FAIL rand%0d a=%0d b=%0d got lat=%0d q=%0d r=%0d ovf=%b dbz=%b want lat=32 q=%0d r=%0d ovf=%b dbz=%b",
                         i, a, b, lat, $signed(q), $signed(r), ov, dz,
                         $signed(eq), $signed(er), eov, edz);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, guard;
        logic [15:0] eq, er;
        logic eov, edz;
        logic stable_ok;
        ref_div(-12345, 100, eq, er, eov, edz);
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        in_valid = 1'b1;
        dividend = -31'sd12345;
        divisor  = 15'd100;
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge ap_clk);
            lat++;
            @(negedge ap_clk);
            if (out_valid) break;
        end
        checks++;
        if (lat != 32 || !out_valid) begin
            failures++;
            $display("FAIL bp_latency got %0d want 32", lat);
        end
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_valid = 1'b1;
                dividend = 31'sd999;
                divisor  = 15'd1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge ap_clk);
            @(negedge ap_clk);
            if ({out_valid, in_ready, quot, rem, ovf, dbz} !== {2'b10, eq, er, eov, edz}) begin
                stable_ok = 1'b0;
                $display("FAIL bp_hold cycle %0d got ov=%b ir=%b q=%0d r=%0d want ov=1 ir=0 q=%0d r=%0d",
                         c, out_valid, in_ready, $signed(quot), $signed(rem),
                         $signed(eq), $signed(er));
            end
        end
        in_valid = 1'b0;
        checks++;
        if (!stable_ok) failures++;
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        // A pulse accepted during the hold would now show as busy.
        repeat (3) @(negedge ap_clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL bp_no_sneak_accept got out_valid=%b in_ready=%b want 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat, guard;
        logic [15:0] q, r;
        logic ov, dz, ova, ira;
        // Leave nonzero outputs behind so the reset clearing is observable.
        run_op(-31'sd100, 15'd7, lat, q, r, ov, dz, ova, ira);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge ap_clk);
            guard++;
        end
        in_valid = 1'b1;
        dividend = 31'sd5000;
        divisor  = 15'd3;
        @(posedge ap_clk);
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, quot, rem, ovf, dbz} !== 36'h0) begin
            failures++;
            $display("FAIL midreset_clear got ov=%b ir=%b q=%h r=%h ovf=%b dbz=%b want all 0",
                     out_valid, in_ready, quot, rem, ovf, dbz);
        end
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run_op(31'sd1000, 15'd10, lat, q, r, ov, dz, ova, ira);
        checks++;
        if (lat != 32 || {q, r, ov, dz} !== {16'd100, 16'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreset_next got lat=%0d q=%0d r=%0d ovf=%b dbz=%b want lat=32 q=100 r=0 ovf=0 dbz=0",
                     lat, $signed(q), $signed(r), ov, dz);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
